// File: rtl/md_pkg.sv
// Shared types and constants for the multiply/divide engine.
// Contents: FSM state encoding, op-select constants, and a
// constant-evaluable log2 helper used to size the step counter.
package md_pkg;

    typedef enum logic [2:0] {
        MD_IDLE     = 3'd0,
        MD_MUL      = 3'd1,
        MD_DIV_PREP = 3'd2,
        MD_DIV_ITER = 3'd3,
        MD_DIV_FIX  = 3'd4,
        MD_DONE     = 3'd5
    } md_state_t;

    localparam logic MD_OP_MUL = 1'b1;
    localparam logic MD_OP_DIV = 1'b0;

    // Smallest r with 2**r >= v.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/mul_div_unit_if.sv
// E-stage <-> multiply/divide engine connection.
// master: E-stage side (drives request, cancel, hold; reads stall/result).
// slave : engine side.
interface mul_div_unit_if #(parameter int WIDTH = 32);
    logic             start;
    logic             op_mul;
    logic             op_signed;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cancel;
    logic             hold;
    logic             stall;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             div_by_zero;

    modport master (
        output start, op_mul, op_signed, a, b, cancel, hold,
        input  stall, done, hi, lo, div_by_zero
    );

    modport slave (
        input  start, op_mul, op_signed, a, b, cancel, hold,
        output stall, done, hi, lo, div_by_zero
    );
endinterface

// File: rtl/mul_div_unit_div_radix2_core.sv
// Radix-2 restoring divider datapath (unsigned magnitudes only).
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   load              capture dividend/divisor, clear partial remainder
//   step              retire one quotient bit (MSB first)
//   dividend, divisor unsigned operands
//   quotient, remainder results, valid after WIDTH steps
module div_radix2_core #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             step,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;

    always_comb begin
        // Quotient register doubles as the dividend shifter: its MSB
        // feeds the partial remainder while quotient bits enter at the LSB.
        shifted = {rem_q, quo_q[WIDTH-1]};
        diff    = shifted - {1'b0, dvs_q};
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        if (load) begin
            rem_d = '0;
            quo_d = dividend;
            dvs_d = divisor;
        end else if (step) begin
            // diff[WIDTH] is the borrow: set means the trial subtract failed.
            if (!diff[WIDTH]) begin
                rem_d = diff[WIDTH-1:0];
                quo_d = {quo_q[WIDTH-2:0], 1'b1};
            end else begin
                rem_d = shifted[WIDTH-1:0];
                quo_d = {quo_q[WIDTH-2:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rem_q <= '0;
            quo_q <= '0;
            dvs_q <= '0;
        end else begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            dvs_q <= dvs_d;
        end
    end

    assign quotient  = quo_q;
    assign remainder = rem_q;
endmodule

// File: rtl/mul_div_unit.sv
// Multi-cycle multiply/divide engine for the E stage; produces {hi, lo}.
// Ports:
//   clk, rst  clock, synchronous active-high reset
//   bus       mul_div_unit_if.slave: start/op_mul/op_signed/a/b request,
//             cancel (E flush), hold (other stall), stall/done/hi/lo/
//             div_by_zero result side.
// Multiply: product pipeline of MUL_LATENCY registers, done MUL_LATENCY
// cycles after accept. Divide: WIDTH+2 cycles, 2 cycles for b==0.
module mul_div_unit
    import md_pkg::*;
#(
    parameter int WIDTH          = 32,
    parameter int MUL_LATENCY    = 2,
    parameter int SIGNED_OVF_SAT = 1
) (
    input logic           clk,
    input logic           rst,
    mul_div_unit_if.slave bus
);
    localparam int CW = clog2((WIDTH > 4) ? WIDTH : 4);
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    md_state_t        state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
    logic             op_mul_q, op_mul_d, op_signed_q, op_signed_d;
    logic             q_neg_q, q_neg_d, r_neg_q, r_neg_d;
    logic             dz_q, dz_d, div_by_zero_q, div_by_zero_d;
    logic             core_load, core_step;
    logic [WIDTH-1:0] a_abs, b_abs, quo, rem, q_fix, r_fix;

    logic [MUL_LATENCY-1:0][2*WIDTH-1:0] mp_q, mp_d;
    logic [WIDTH:0]                      ma, mb;
    logic signed [2*WIDTH-1:0]           ma_x, mb_x, mprod;

    // Product is formed from the live request operands so stage 0 holds
    // it right after the accept edge. The WIDTH+1 sign-extended operands
    // are widened to 2*WIDTH; the low 2*WIDTH product bits are unchanged.
    always_comb begin
        ma    = {bus.op_signed & bus.a[WIDTH-1], bus.a};
        mb    = {bus.op_signed & bus.b[WIDTH-1], bus.b};
        ma_x  = (2*WIDTH)'($signed(ma));
        mb_x  = (2*WIDTH)'($signed(mb));
        mprod = ma_x * mb_x;
        mp_d[0] = mprod;
        for (int k = 1; k < MUL_LATENCY; k++) mp_d[k] = mp_q[k-1];
    end

    div_radix2_core #(.WIDTH(WIDTH)) u_core (
        .clk       (clk),
        .rst       (rst),
        .load      (core_load),
        .step      (core_step),
        .dividend  (a_abs),
        .divisor   (b_abs),
        .quotient  (quo),
        .remainder (rem)
    );

    always_comb begin
        a_abs = (op_signed_q && a_q[WIDTH-1]) ? -a_q : a_q;
        b_abs = (op_signed_q && b_q[WIDTH-1]) ? -b_q : b_q;
        q_fix = q_neg_q ? -quo : quo;
        r_fix = r_neg_q ? -rem : rem;
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        a_d           = a_q;
        b_d           = b_q;
        op_mul_d      = op_mul_q;
        op_signed_d   = op_signed_q;
        q_neg_d       = q_neg_q;
        r_neg_d       = r_neg_q;
        dz_d          = dz_q;
        hi_d          = hi_q;
        lo_d          = lo_q;
        div_by_zero_d = div_by_zero_q;
        core_load     = 1'b0;
        core_step     = 1'b0;

        // Flush abandons the instruction; results from the prior op survive.
        if (bus.cancel) begin
            state_d = MD_IDLE;
        end else begin
            unique case (state_q)
                MD_IDLE: begin
                    if (bus.start) begin
                        a_d         = bus.a;
                        b_d         = bus.b;
                        op_mul_d    = bus.op_mul;
                        op_signed_d = bus.op_signed;
                        if (bus.op_mul == MD_OP_MUL) begin
                            state_d = MD_MUL;
                            cnt_d   = CW'(MUL_LATENCY - 1);
                        end else begin
                            state_d = MD_DIV_PREP;
                        end
                    end
                end
                MD_MUL: begin
                    if (cnt_q == '0) begin
                        hi_d          = mp_q[MUL_LATENCY-1][2*WIDTH-1:WIDTH];
                        lo_d          = mp_q[MUL_LATENCY-1][WIDTH-1:0];
                        div_by_zero_d = 1'b0;
                        state_d       = MD_DONE;
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
                MD_DIV_PREP: begin
                    q_neg_d = op_signed_q & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
                    r_neg_d = op_signed_q & a_q[WIDTH-1];
                    dz_d    = (b_q == '0);
                    if (b_q == '0) begin
                        state_d = MD_DIV_FIX;
                    end else begin
                        core_load = 1'b1;
                        cnt_d     = CW'(WIDTH - 1);
                        state_d   = MD_DIV_ITER;
                    end
                end
                MD_DIV_ITER: begin
                    core_step = 1'b1;
                    if (cnt_q == '0) state_d = MD_DIV_FIX;
                    else             cnt_d   = cnt_q - CW'(1);
                end
                MD_DIV_FIX: begin
                    if (dz_q) begin
                        lo_d = '1;
                        hi_d = a_q;
                    end else if (SIGNED_OVF_SAT != 0 && op_signed_q &&
                                 a_q == MIN_VAL && b_q == '1) begin
                        lo_d = MIN_VAL;
                        hi_d = '0;
                    end else begin
                        lo_d = q_fix;
                        hi_d = r_fix;
                    end
                    div_by_zero_d = dz_q && (op_mul_q == MD_OP_DIV);
                    state_d       = MD_DONE;
                end
                MD_DONE: begin
                    // Leaving DONE is the cycle E advances; a still-high
                    // start here belongs to the finished instruction.
                    if (!bus.hold) state_d = MD_IDLE;
                end
                default: state_d = MD_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= MD_IDLE;
            cnt_q         <= '0;
            a_q           <= '0;
            b_q           <= '0;
            op_mul_q      <= 1'b0;
            op_signed_q   <= 1'b0;
            q_neg_q       <= 1'b0;
            r_neg_q       <= 1'b0;
            dz_q          <= 1'b0;
            hi_q          <= '0;
            lo_q          <= '0;
            div_by_zero_q <= 1'b0;
            mp_q          <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            a_q           <= a_d;
            b_q           <= b_d;
            op_mul_q      <= op_mul_d;
            op_signed_q   <= op_signed_d;
            q_neg_q       <= q_neg_d;
            r_neg_q       <= r_neg_d;
            dz_q          <= dz_d;
            hi_q          <= hi_d;
            lo_q          <= lo_d;
            div_by_zero_q <= div_by_zero_d;
            mp_q          <= mp_d;
        end
    end

    // Combinational so the pipeline freezes in the request cycle itself.
    assign bus.stall = ~bus.cancel &
                       (((state_q == MD_IDLE) & bus.start) |
                        (state_q == MD_MUL) | (state_q == MD_DIV_PREP) |
                        (state_q == MD_DIV_ITER) | (state_q == MD_DIV_FIX));
    assign bus.done        = (state_q == MD_DONE) & ~bus.cancel;
    assign bus.hi          = hi_q;
    assign bus.lo          = lo_q;
    assign bus.div_by_zero = div_by_zero_q;
endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Parametrised multi-cycle multiply/divide engine for the execute stage of the MIPS pipeline.
- Replaces the fixed 32-bit divider that drives the pipeline's div stall, and adds multiply modes, configurable width and configurable multiply latency.
- Produces {hi, lo} for the HI/LO write path.
- Supports cancellation from exception flush and result hold while another stall (memory or fetch) freezes the pipeline.

Parameters:
- WIDTH, 32: operand width; product and quotient/remainder pair are 2*WIDTH.
- MUL_LATENCY, 2: cycles from accepted multiply to done. Legal range 1..4. Implemented as a product register pipeline.
- SIGNED_OVF_SAT, 1: if 1, signed MIN / -1 yields lo=MIN, hi=0; if 0, the result is whatever the iteration produces.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  operation request; held high by the E-stage instruction until it leaves E
- op_mul  in  1  1=multiply, 0=divide
- op_signed  in  1  1=signed operands, 0=unsigned
- a  in  WIDTH  multiplicand / dividend
- b  in  WIDTH  multiplier / divisor
- cancel  in  1  flush of E stage (exception/eret); aborts the operation
- hold  in  1  pipeline frozen by another stall; result must persist
- stall  out  1  E-stage stall request
- done  out  1  result valid this cycle
- hi  out  WIDTH  product upper half / remainder
- lo  out  WIDTH  product lower half / quotient
- div_by_zero  out  1  sticky with result; set when a divide had b==0

Behaviour:
- Reset values: state IDLE; hi=0, lo=0, done=0, div_by_zero=0. Stall is 0 while start=0.
- States: IDLE, MUL, DIV_PREP, DIV_ITER, DIV_FIX, DONE.
- IDLE:
  - start=1 and cancel=0: latch a, b, op_mul, op_signed.
  - Go to MUL if op_mul, else DIV_PREP.
  - start is sampled only in IDLE.
- MUL: counter counts MUL_LATENCY cycles, then DONE. Signed product uses a WIDTH+1 sign-extended multiply.
- DIV_PREP (1 cycle):
  - Take absolute values if signed. Record quotient sign (a^b) and remainder sign (a).
  - b==0: skip iteration and go to DIV_FIX with lo=all ones, hi=a, div_by_zero=1.
- DIV_ITER: radix-2 restoring division, one quotient bit per cycle. Counter runs WIDTH-1 down to 0. Counter 0 leads to DIV_FIX.
- DIV_FIX (1 cycle):
  - Apply signs. Remainder takes the dividend's sign. Apply SIGNED_OVF_SAT rule.
  - Write hi/lo, then go to DONE.
- Latency from accepting start to done=1:
  - Multiply: MUL_LATENCY cycles.
  - Divide: WIDTH+2 cycles.
  - Divide by zero: 2 cycles.
- DONE:
  - done=1 and stall=0.
  - hold=1: stay in DONE.
  - hold=0: go to IDLE next cycle; this is the cycle E advances.
  - A start still high in DONE never restarts the same instruction.
- stall = (state==IDLE & start & ~cancel) | state in {MUL, DIV_PREP, DIV_ITER, DIV_FIX}. Stall is combinational so the pipeline freezes in the request cycle.
- cancel has priority over everything except rst:
  - From any state, go to IDLE next cycle.
  - done stays 0, and hi/lo/div_by_zero keep their previous values.
  - stall drops in the same cycle cancel is asserted.
- hi/lo change only on the DIV_FIX write or the MUL final cycle, so consumers may read them in DONE or later.
- rst mid-operation: next cycle all state is at reset values. No partial result is visible.
- hold during busy states has no effect; iteration continues.

Decomposition:
- Package md_pkg holds:
  - the state enum md_state_t (6 values, 3-bit encoding);
  - constants MD_OP_MUL=1 and MD_OP_DIV=0;
  - localparam function clog2 for the counter width.
- Sub-module div_radix2_core (WIDTH): remainder/quotient shift registers plus a subtract-compare, stepping one bit per enable. The FSM, sign handling and multiply pipeline stay in mul_div_unit.

Test Plan:
- Unsigned multiply:
  - Stimulus: WIDTH=32, MUL_LATENCY=2, a=0xFFFF_FFFF, b=0x2, start, op_mul=1, op_signed=0.
  - Required: stall=1 for 2 cycles, then done=1 with hi=0x1, lo=0xFFFF_FFFE.
- Signed divide:
  - Stimulus: a=-7 (0xFFFF_FFF9), b=2, op_signed=1.
  - Required: done exactly 34 cycles after accept, lo=0xFFFF_FFFD (-3), hi=0xFFFF_FFFF (-1).
- Divide by zero:
  - Stimulus: a=0x1234, b=0.
  - Required: done after 2 cycles, lo=0xFFFF_FFFF, hi=0x1234, div_by_zero=1.
- Signed overflow:
  - Stimulus: a=0x8000_0000, b=0xFFFF_FFFF, signed, SIGNED_OVF_SAT=1.
  - Required: lo=0x8000_0000, hi=0.
- Cancel:
  - Stimulus: start a divide, assert cancel at iteration 10.
  - Required: stall=0 that cycle, IDLE next cycle, done never asserted, hi/lo unchanged from the previous result. A new multiply 3*5 then yields lo=15.
- Hold plus back-to-back:
  - Stimulus: hold=1 for 5 cycles after done, with start kept high.
  - Required: done stays 1 and there is no restart. hold=0 returns to IDLE. Next start with a=6, b=3 divide gives lo=2, hi=0.
  - Also with WIDTH=16: 0xFFFF/0x10 unsigned gives lo=0x0FFF, hi=0xF after 18 cycles.
